// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: one-entry skid register with operand select, EX/MEM and MEM/WB forwarding,
// and load-use stall. Forwarding and the load-use stall exist only when PIRISC_FORWARD_EN is defined.
module alu_operand_stage #(
  parameter int VAR_WIDTH  = 32,
  parameter int OP_WIDTH   = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [VAR_WIDTH-1:0]  in_rs1_data,
  input  logic [VAR_WIDTH-1:0]  in_rs2_data,
  input  logic [VAR_WIDTH-1:0]  in_imm,
  input  logic [VAR_WIDTH-1:0]  in_pc,
  input  logic [OP_WIDTH-1:0]   in_alu_op,
  input  logic [1:0]            in_a_sel,
  input  logic                  in_b_sel,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic                  in_is_load,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_we,
  input  logic                  exmem_is_load,
  input  logic [VAR_WIDTH-1:0]  exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_we,
  input  logic [VAR_WIDTH-1:0]  memwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   alu_opcode,
  output logic [VAR_WIDTH-1:0]  alu_a,
  output logic [VAR_WIDTH-1:0]  alu_b,
  output logic [VAR_WIDTH-1:0]  out_rs2_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,
  output logic                  out_is_load,
  output logic [VAR_WIDTH-1:0]  out_pc,
  output logic                  load_hazard
);

  logic                  held_valid_q, held_valid_d;
  logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
  logic [1:0]            a_sel_q, a_sel_d;
  logic                  b_sel_q, b_sel_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [VAR_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [VAR_WIDTH-1:0]  imm_q, imm_d, pc_q, pc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rd_we_q, rd_we_d;
  logic                  is_load_q, is_load_d;

  logic [VAR_WIDTH-1:0]  fwd1, fwd2;
  logic                  out_fire;

`ifdef PIRISC_FORWARD_EN
  logic ex_match1, ex_match2, wb_match1, wb_match2;

  assign ex_match1 = exmem_we && (exmem_rd == rs1_q) && (rs1_q != '0);
  assign ex_match2 = exmem_we && (exmem_rd == rs2_q) && (rs2_q != '0);
  assign wb_match1 = memwb_we && (memwb_rd == rs1_q) && (rs1_q != '0);
  assign wb_match2 = memwb_we && (memwb_rd == rs2_q) && (rs2_q != '0);

  // EX/MEM is the newer producer, so it beats MEM/WB.
  assign fwd1 = ex_match1 ? exmem_result : (wb_match1 ? memwb_result : op1_q);
  assign fwd2 = ex_match2 ? exmem_result : (wb_match2 ? memwb_result : op2_q);

  assign load_hazard = held_valid_q && exmem_is_load && (ex_match1 || ex_match2);
`else
  logic unused_fwd_inputs;

  assign unused_fwd_inputs = ^{exmem_rd, exmem_we, exmem_is_load, exmem_result,
                               memwb_rd, memwb_we, memwb_result, rs1_q, rs2_q};
  assign fwd1        = op1_q;
  assign fwd2        = op2_q;
  assign load_hazard = 1'b0;
`endif

  assign out_valid = held_valid_q && !load_hazard;
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !held_valid_q || out_fire;

  always_comb begin
    held_valid_d = held_valid_q;
    opcode_d     = opcode_q;
    a_sel_d      = a_sel_q;
    b_sel_d      = b_sel_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    is_load_d    = is_load_q;
    if (in_valid && in_ready && !flush) begin
      held_valid_d = 1'b1;
      opcode_d     = in_alu_op;
      a_sel_d      = in_a_sel;
      b_sel_d      = in_b_sel;
      rs1_d        = in_rs1;
      rs2_d        = in_rs2;
      op1_d        = in_rs1_data;
      op2_d        = in_rs2_data;
      imm_d        = in_imm;
      pc_d         = in_pc;
      rd_d         = in_rd;
      rd_we_d      = in_rd_we;
      is_load_d    = in_is_load;
    end else if (out_fire || flush) begin
      held_valid_d = 1'b0;
    end else if (held_valid_q) begin
      // Absorb results retiring during a stall so they are not lost once MEM/WB moves on.
      op1_d = fwd1;
      op2_d = fwd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid_q <= 1'b0;
      opcode_q     <= '0;
      a_sel_q      <= '0;
      b_sel_q      <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      is_load_q    <= 1'b0;
    end else begin
      held_valid_q <= held_valid_d;
      opcode_q     <= opcode_d;
      a_sel_q      <= a_sel_d;
      b_sel_q      <= b_sel_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      is_load_q    <= is_load_d;
    end
  end

  always_comb begin
    alu_a = fwd1;
    case (a_sel_q)
      2'd1:    alu_a = pc_q;
      2'd2:    alu_a = '0;
      default: alu_a = fwd1;
    endcase
  end

  assign alu_b        = b_sel_q ? imm_q : fwd2;
  assign out_rs2_data = fwd2;
  assign alu_opcode   = opcode_q;
  assign out_rd       = rd_q;
  assign out_rd_we    = rd_we_q;
  assign out_is_load  = is_load_q;
  assign out_pc       = pc_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus random traffic against a
// behavioural model of the one-entry stage; follows PIRISC_FORWARD_EN like the design.
module tb_alu_operand_stage;

`ifdef PIRISC_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [3:0] ALUADD = 4'd0;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [3:0]  in_alu_op;
  logic [1:0]  in_a_sel;
  logic        in_b_sel;
  logic [4:0]  in_rd;
  logic        in_rd_we, in_is_load, flush;
  logic [4:0]  exmem_rd;
  logic        exmem_we, exmem_is_load;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_we;
  logic [31:0] memwb_result;
  logic        out_valid, out_ready;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, out_rs2_data, out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_is_load, load_hazard;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_alu_op(in_alu_op), .in_a_sel(in_a_sel),
    .in_b_sel(in_b_sel), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .flush(flush), .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_is_load(exmem_is_load),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_we(memwb_we),
    .memwb_result(memwb_result), .out_valid(out_valid), .out_ready(out_ready),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_pc(out_pc),
    .load_hazard(load_hazard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Model of the held instruction.
  bit          m_valid;
  logic [3:0]  m_op;
  logic [1:0]  m_a_sel;
  logic        m_b_sel;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_op1, m_op2, m_imm, m_pc;
  logic        m_rd_we, m_is_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] newest(input logic [4:0] rs, input logic [31:0] raw);
    if (!FWD || rs == 5'd0) return raw;
    if (exmem_we && exmem_rd == rs) return exmem_result;
    if (memwb_we && memwb_rd == rs) return memwb_result;
    return raw;
  endfunction

  function automatic bit m_hazard();
    return FWD && m_valid && exmem_is_load && exmem_we &&
           ((exmem_rd == m_rs1 && m_rs1 != 5'd0) || (exmem_rd == m_rs2 && m_rs2 != 5'd0));
  endfunction

  function automatic logic [31:0] m_alu_a();
    if (m_a_sel == 2'd1) return m_pc;
    if (m_a_sel == 2'd2) return 32'd0;
    return newest(m_rs1, m_op1);
  endfunction

  // Advance the model by one clock; called at the rising edge with inputs still stable.
  task automatic model_step();
    bit fire, rdy;
    fire = m_valid && !m_hazard() && out_ready;
    rdy  = !m_valid || fire;
    if (rst) begin
      m_valid = 0; m_op = 0; m_a_sel = 0; m_b_sel = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_op1 = 0; m_op2 = 0; m_imm = 0; m_pc = 0; m_rd_we = 0; m_is_load = 0;
    end else if (in_valid && rdy && !flush) begin
      m_valid = 1; m_op = in_alu_op; m_a_sel = in_a_sel; m_b_sel = in_b_sel;
      m_rs1 = in_rs1; m_rs2 = in_rs2; m_op1 = in_rs1_data; m_op2 = in_rs2_data;
      m_imm = in_imm; m_pc = in_pc; m_rd = in_rd; m_rd_we = in_rd_we; m_is_load = in_is_load;
    end else if (fire || flush) begin
      m_valid = 0;
    end else if (m_valid) begin
      m_op1 = newest(m_rs1, m_op1);
      m_op2 = newest(m_rs2, m_op2);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid && !m_hazard()});
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || (!m_hazard() && out_ready)});
      chk("load_hazard", {31'd0, load_hazard}, {31'd0, m_hazard()});
      chk("alu_opcode", {28'd0, alu_opcode}, {28'd0, m_op});
      chk("alu_a", alu_a, m_alu_a());
      chk("alu_b", alu_b, m_b_sel ? m_imm : newest(m_rs2, m_op2));
      chk("out_rs2_data", out_rs2_data, newest(m_rs2, m_op2));
      chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      chk("out_flags", {30'd0, out_rd_we, out_is_load}, {30'd0, m_rd_we, m_is_load});
      chk("out_pc", out_pc, m_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; flush = 0; out_ready = 1; rst = 0;
    exmem_we = 0; exmem_is_load = 0; exmem_rd = 0; exmem_result = 0;
    memwb_we = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                       input logic [31:0] d2, input logic [1:0] asel, input logic bsel,
                       input logic [31:0] imm, input logic [3:0] op);
    in_valid = 1; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_a_sel = asel; in_b_sel = bsel; in_imm = imm; in_alu_op = op;
    in_pc = 32'h100 + {27'd0, rs1}; in_rd = 5'd9; in_rd_we = 1; in_is_load = 0;
  endtask

  initial begin
    quiet();
    instr(5'd0, 0, 5'd0, 0, 2'd0, 1'b0, 0, 4'd0);
    in_valid = 0;
    rst = 1;
    step();
    chk_on = 1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst alu_opcode", {28'd0, alu_opcode}, 32'd0);
    chk("rst load_hazard", {31'd0, load_hazard}, 32'd0);
    rst = 0;

    // Back-to-back accepts.
    instr(5'd1, 32'd5, 5'd6, 32'd1, 2'd0, 1'b1, 32'd7, ALUADD);
    step();
    instr(5'd2, 32'd9, 5'd6, 32'd1, 2'd0, 1'b1, 32'd3, 4'd1);
    #1;
    chk("b2b valid", {31'd0, out_valid}, 32'd1);
    chk("b2b alu_a", alu_a, 32'd5);
    chk("b2b alu_b", alu_b, 32'd7);
    chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 0;
    #1;
    chk("b2b second alu_a", alu_a, 32'd9);
    chk("b2b second alu_b", alu_b, 32'd3);
    step();

    // Forward priority, then rs1 = x0 never forwards.
    instr(5'd3, 32'h11, 5'd6, 32'd0, 2'd0, 1'b1, 32'd0, 4'd2);
    step();
    in_valid = 0;
    exmem_we = 1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_we = 1; memwb_rd = 5'd3; memwb_result = 32'hBB;
    #1;
    chk("prio alu_a", alu_a, FWD ? 32'hAA : 32'h11);
    step();
    quiet();
    instr(5'd0, 32'h22, 5'd6, 32'd0, 2'd0, 1'b1, 32'd0, 4'd2);
    step();
    in_valid = 0;
    exmem_we = 1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_we = 1; memwb_rd = 5'd0; memwb_result = 32'hBB;
    #1;
    chk("x0 alu_a", alu_a, 32'h22);
    step();
    quiet();

    // Stall with a MEM/WB result retiring in the first stalled cycle.
    instr(5'd7, 32'd0, 5'd2, 32'h10, 2'd0, 1'b0, 32'd0, 4'd3);
    step();
    instr(5'd8, 32'd1, 5'd8, 32'd1, 2'd0, 1'b0, 32'd0, 4'd4);
    out_ready = 0;
    memwb_we = 1; memwb_rd = 5'd2; memwb_result = 32'h55;
    #1;
    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    step();
    memwb_we = 0; memwb_result = 32'h0;
    #1;
    chk("stall in_ready2", {31'd0, in_ready}, 32'd0);
    step();
    step();
    in_valid = 0; out_ready = 1;
    #1;
    chk("stall release valid", {31'd0, out_valid}, 32'd1);
    chk("stall release alu_b", alu_b, FWD ? 32'h55 : 32'h10);
    step();

    // Load-use hazard resolved through MEM/WB.
    instr(5'd5, 32'd0, 5'd4, 32'h99, 2'd0, 1'b0, 32'd0, 4'd5);
    step();
    in_valid = 0;
    exmem_we = 1; exmem_is_load = 1; exmem_rd = 5'd4; exmem_result = 32'hDEAD;
    #1;
    chk("lu out_valid", {31'd0, out_valid}, FWD ? 32'd0 : 32'd1);
    chk("lu load_hazard", {31'd0, load_hazard}, FWD ? 32'd1 : 32'd0);
    step();
    quiet();
    memwb_we = 1; memwb_rd = 5'd4; memwb_result = 32'h1234;
    #1;
    if (FWD) begin
      chk("lu resolved valid", {31'd0, out_valid}, 32'd1);
      chk("lu resolved alu_b", alu_b, 32'h1234);
    end
    step();
    quiet();

    // Flush with a concurrent accept attempt and a stalled output.
    instr(5'd1, 32'd1, 5'd1, 32'd1, 2'd1, 1'b1, 32'd1, 4'd6);
    step();
    instr(5'd2, 32'd2, 5'd2, 32'd2, 2'd2, 1'b1, 32'd2, 4'd7);
    out_ready = 0; flush = 1;
    step();
    quiet();
    #1;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Reset during a stall.
    instr(5'd3, 32'd3, 5'd3, 32'd3, 2'd0, 1'b0, 32'd0, 4'd5);
    out_ready = 0;
    step();
    in_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("rst stall out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst stall opcode", {28'd0, alu_opcode}, 32'd0);
    step();

    // Random traffic on a small register set so forwarding matches are frequent.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      in_valid      = $urandom_range(0, 3) != 0;
      out_ready     = $urandom_range(0, 3) != 0;
      in_rs1        = 5'($urandom_range(0, 7));
      in_rs2        = 5'($urandom_range(0, 7));
      in_rs1_data   = $urandom;
      in_rs2_data   = $urandom;
      in_imm        = $urandom;
      in_pc         = $urandom;
      in_alu_op     = 4'($urandom_range(0, 15));
      in_a_sel      = 2'($urandom_range(0, 3));
      in_b_sel      = 1'($urandom_range(0, 1));
      in_rd         = 5'($urandom_range(0, 31));
      in_rd_we      = 1'($urandom_range(0, 1));
      in_is_load    = 1'($urandom_range(0, 1));
      exmem_rd      = 5'($urandom_range(0, 7));
      exmem_we      = 1'($urandom_range(0, 1));
      exmem_is_load = ($urandom_range(0, 3) == 0);
      exmem_result  = $urandom;
      memwb_rd      = 5'($urandom_range(0, 7));
      memwb_we      = 1'($urandom_range(0, 1));
      memwb_result  = $urandom;
      step();
    end

    quiet();
    step();
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
